// File: rtl/sram1rw_req_adapter.sv
// Valid/ready request adapter for a 4096x8 single-port SRAM macro.
// Drives the macro's active-low pins and buffers read data in a 2-entry FIFO.
module sram1rw_req_adapter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  input  logic [DATA_W-1:0] sram_o
);

  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [DATA_W-1:0] buf_q [2];

  logic       fire;
  logic       pop;
  logic       capture;
  logic [2:0] pending;

  assign resp_valid = (occ_q != 2'd0);
  assign resp_rdata = buf_q[head_q];
  assign pop        = resp_valid & resp_ready;
  assign capture    = inflight_q;

  // Slots committed after this edge; pop implies occ >= 1, so no underflow.
  assign pending   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign req_ready = ~reset & (pending < 3'd2);
  assign fire      = req_valid & req_ready;

  assign sram_a   = req_addr;
  assign sram_i   = req_wdata;
  assign sram_csb = ~fire;
  assign sram_web = ~(fire & req_we);
  assign sram_oeb = ~(fire & ~req_we);

  always_comb begin
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = fire & ~req_we;
    if (capture && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (!capture && pop) begin
      occ_d = occ_q - 2'd1;
    end
    if (pop) begin
      head_d = ~head_q;
    end
    if (capture) begin
      tail_d = ~tail_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // The macro's O is only meaningful in the cycle right after a read fire.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_q[tail_q] <= sram_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(capture && occ_q == 2'd2));
      assert (occ_q <= 2'd2);
      assert (sram_web || sram_oeb);
    end
  end

endmodule
